// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and sizing helper for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index width: ceil(log2(w)), never below one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full-adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell per clock, LSB first, with IDLE/RUN/DONE handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    idx;
  logic             cell_sum;
  logic             cell_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          // Operands shift right so the cell always sees the current bit at [0].
          sum[idx] <= cell_sum;
          carry    <= cell_cout;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          if (idx == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= cell_cout;
            overflow <= carry ^ cell_cout;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: timeline/arithmetic model checked every cycle, plus directed literals.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout, overflow;
  logic [W-1:0] sum;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       ready2, busy2, done2, cout2, overflow2;
  logic [1:0] sum2;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(overflow2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: t0 = edge number of the accepted start; everything else follows from elapsed edges.
  int           cyc = 0;
  int           t0  = -1;
  int           k;
  logic [W-1:0] ma, mb;
  logic [W:0]   full;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; t0 = -1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      if ((t0 < 0 || cyc - t0 >= W + 2) && start) begin
        t0 = cyc; ma = a; mb = b;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        m_sum = '0;
      end else if (t0 >= 0 && cyc - t0 >= 1 && cyc - t0 <= W) begin
        k = cyc - t0 - 1;
        m_sum[k] = full[k];
        if (k == W - 1) begin
          m_cout = full[W];
          m_ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
        end
      end
      cyc++;
    end
  end

  state_t ph;
  int     e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (t0 < 0) ph = IDLE;
      else begin
        e  = cyc - 1 - t0;
        ph = (e <= W - 1) ? RUN : (e == W) ? DONE : IDLE;
      end
      chk("ready", ready, ph == IDLE);
      chk("busy", busy, ph == RUN);
      chk("done", done, ph == DONE);
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
      chk("overflow", overflow, m_ovf);
    end
  end

  // Launch at a negedge, wait (bounded) for done, then pin latency, result and single pulse.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit hold);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      if (hold && n == 3) begin a = ~ta; b = ~tb_; end
    end while (!done && n < 40);
    start = 1'b0;
    chk({nm, "_latency"}, n - 1, W);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, overflow, eo);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n, s, sa, sb;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("inc",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op("wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("povf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("novf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("ones",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("hold",  8'h5A, 8'h21, 1'b1, 8'h7C, 1'b0, 1'b0, 1'b1);

    // Abort mid-RUN, then restart on the first edge after reset release.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", cout, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; a = 8'h33; b = 8'h11; cin = 1'b0; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (!done && n < 40);
    chk("restart_latency", n - 1, W);
    chk("restart_sum", sum, 8'h44);
    chk("restart_cout", cout, 1'b0);

    // WIDTH=2 instance: every a/b/cin combination against plain integer arithmetic.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          a2 = i[1:0]; b2 = j[1:0]; cin2 = c[0]; start2 = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            n++;
            start2 = 1'b0;
          end while (!done2 && n < 20);
          s  = i + j + c;
          sa = (i >= 2) ? i - 4 : i;
          sb = (j >= 2) ? j - 4 : j;
          chk("w2_latency", n - 1, 2);
          chk("w2_sum", sum2, s[1:0]);
          chk("w2_cout", cout2, s >= 4);
          chk("w2_ovf", overflow2, (sa + sb + c > 1) || (sa + sb + c < -2));
          @(negedge clk);
        end
      end
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
